// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data load-store) arbiter onto one
// shared memory port. Grants are one-hot on `grant` (bit0 imem, bit1 dmem).
// Optional feature: define MEM_ARB_RR_EN to alternate between the two
// requesters when both are pending in IDLE. Without it, dmem always wins.
//
// Handshake: a requester raises its enable(s) with stable address/data and
// holds them until its ready pulse. The ready is the shared mem_ready, passed
// through only while that requester owns the port. Read data is valid only in
// the cycle its ready is high. Dropping all enables before ready aborts the
// access. If memory stays silent for TIMEOUT cycles, the access is abandoned
// and timeout_err pulses.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] imem_rd_addr,
    input  logic              imem_rd_enable,
    output logic [DATA_W-1:0] imem_rd_data,
    output logic              imem_rd_ready,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_r_enable,
    input  logic              dmem_w_enable,
    input  logic [1:0]        dmem_w_size,
    input  logic [DATA_W-1:0] dmem_w_data,
    output logic [DATA_W-1:0] dmem_r_data,
    output logic              dmem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_r_enable,
    output logic              mem_w_enable,
    output logic [1:0]        mem_w_size,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data,
    input  logic              mem_ready,
    output logic [1:0]        grant,
    output logic              timeout_err,
    output logic [1:0]        fsm_state
);

    // Grant states are encoded so the state register is the one-hot grant.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
    logic       arb_en_q;
    logic       dmem_req;
    logic       owner_req;
`ifdef MEM_ARB_RR_EN
    logic       ptr_q, ptr_d;   // 0: imem wins a tie, 1: dmem wins a tie
`endif

    assign dmem_req = dmem_r_enable | dmem_w_enable;

    // State, wait counter, error pulse and arbitration enable registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
            arb_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            arb_en_q   <= 1'b1;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin tie-break pointer, starts pointing at imem.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Next-state: arbitrate in IDLE, then complete, abort or time out.
    // The first clock edge after reset release only arms arbitration, so the
    // earliest grant lands on the second edge.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = 1'b0;
        owner_req  = 1'b0;
`ifdef MEM_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                wait_cnt_d = 8'd0;
                if (arb_en_q) begin
`ifdef MEM_ARB_RR_EN
                    if (dmem_req && imem_rd_enable) begin
                        state_d = ptr_q ? GNT_D : GNT_I;
                    end else if (dmem_req) begin
                        state_d = GNT_D;
                    end else if (imem_rd_enable) begin
                        state_d = GNT_I;
                    end
`else
                    if (dmem_req) begin
                        state_d = GNT_D;
                    end else if (imem_rd_enable) begin
                        state_d = GNT_I;
                    end
`endif
                end
            end
            GNT_I, GNT_D: begin
                owner_req = (state_q == GNT_I) ? imem_rd_enable : dmem_req;
                if (mem_ready) begin
                    state_d = IDLE;
`ifdef MEM_ARB_RR_EN
                    ptr_d   = ~ptr_q;
`endif
                end else if (!owner_req) begin
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_q + 8'd1 == TIMEOUT_C) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shared-port mux and ready steering: only the owner sees mem_ready.
    always_comb begin
        mem_addr      = '0;
        mem_r_enable  = 1'b0;
        mem_w_enable  = 1'b0;
        mem_w_size    = 2'd0;
        mem_w_data    = '0;
        imem_rd_ready = 1'b0;
        dmem_ready    = 1'b0;
        case (state_q)
            GNT_I: begin
                mem_addr      = imem_rd_addr;
                mem_r_enable  = imem_rd_enable;
                imem_rd_ready = mem_ready;
            end
            GNT_D: begin
                mem_addr     = dmem_addr;
                mem_r_enable = dmem_r_enable;
                mem_w_enable = dmem_w_enable;
                mem_w_size   = dmem_w_size;
                mem_w_data   = dmem_w_data;
                dmem_ready   = mem_ready;
            end
            default: begin
            end
        endcase
    end

    assign imem_rd_data = mem_r_data;
    assign dmem_r_data  = mem_r_data;
    assign grant        = state_q;
    assign fsm_state    = state_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, hand-written corner sequences, then
// randomized traffic checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0] imem_rd_addr;
    logic          imem_rd_enable;
    logic [DW-1:0] imem_rd_data;
    logic          imem_rd_ready;
    logic [AW-1:0] dmem_addr;
    logic          dmem_r_enable;
    logic          dmem_w_enable;
    logic [1:0]    dmem_w_size;
    logic [DW-1:0] dmem_w_data;
    logic [DW-1:0] dmem_r_data;
    logic          dmem_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_r_enable;
    logic          mem_w_enable;
    logic [1:0]    mem_w_size;
    logic [DW-1:0] mem_w_data;
    logic [DW-1:0] mem_r_data;
    logic          mem_ready;
    logic [1:0]    grant;
    logic          timeout_err;
    logic [1:0]    fsm_state;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .imem_rd_addr(imem_rd_addr), .imem_rd_enable(imem_rd_enable),
        .imem_rd_data(imem_rd_data), .imem_rd_ready(imem_rd_ready),
        .dmem_addr(dmem_addr), .dmem_r_enable(dmem_r_enable),
        .dmem_w_enable(dmem_w_enable), .dmem_w_size(dmem_w_size),
        .dmem_w_data(dmem_w_data), .dmem_r_data(dmem_r_data),
        .dmem_ready(dmem_ready),
        .mem_addr(mem_addr), .mem_r_enable(mem_r_enable),
        .mem_w_enable(mem_w_enable), .mem_w_size(mem_w_size),
        .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
        .mem_ready(mem_ready),
        .grant(grant), .timeout_err(timeout_err), .fsm_state(fsm_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        imem_rd_addr   = '0;
        imem_rd_enable = 1'b0;
        dmem_addr      = '0;
        dmem_r_enable  = 1'b0;
        dmem_w_enable  = 1'b0;
        dmem_w_size    = 2'd0;
        dmem_w_data    = '0;
        mem_r_data     = '0;
        mem_ready      = 1'b0;
    endtask

    // Leaves the DUT idle and armed, positioned just after a falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       ie, dr, dw, rdy;
        logic [1:0] g;
        logic       ir, drd, err;
    } vec_t;
    vec_t tbl[18];

    // ---------------- random-phase model state ----------------
    int            owner;       // 0 none, 1 imem, 2 dmem
    int            waited;
    int            completions;
    bit            err_pend;
    bit            i_act, d_act, d_rd, d_wr;
    logic [AW-1:0] i_addr, d_addr;
    logic [1:0]    d_size;
    logic [DW-1:0] d_data;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]    exp_g;
        logic [AW-1:0] exp_addr;
        logic          exp_re, exp_we, exp_ir, exp_dr, req;
        logic [1:0]    exp_sz;
        logic [DW-1:0] exp_wd, popped;
        int            k;

        // ---- reset state ----
        reset = 1'b1;
        idle_inputs();
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst grant", 64'(grant), 64'(2'b00));
        chk("rst fsm_state", 64'(fsm_state), 64'(2'b00));
        chk("rst timeout_err", 64'(timeout_err), 64'(1'b0));
        chk("rst mem_r_enable", 64'(mem_r_enable), 64'(1'b0));
        chk("rst mem_w_enable", 64'(mem_w_enable), 64'(1'b0));
        chk("rst dmem_ready", 64'(dmem_ready), 64'(1'b0));
        chk("rst imem_rd_ready", 64'(imem_rd_ready), 64'(1'b0));

        // ---- table: grant, abort, mem_ready ignored in idle, timeout ----
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            imem_rd_enable = tbl[i].ie;
            dmem_r_enable  = tbl[i].dr;
            dmem_w_enable  = tbl[i].dw;
            mem_ready      = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d grant", i), 64'(grant), 64'(tbl[i].g));
            chk($sformatf("tbl%0d imem_rd_ready", i), 64'(imem_rd_ready), 64'(tbl[i].ir));
            chk($sformatf("tbl%0d dmem_ready", i), 64'(dmem_ready), 64'(tbl[i].drd));
            chk($sformatf("tbl%0d timeout_err", i), 64'(timeout_err), 64'(tbl[i].err));
        end

        // ---- fetch with mem_ready two cycles after grant ----
        do_reset();
        @(negedge clk);
        imem_rd_enable = 1'b1;
        imem_rd_addr   = 32'h100;
        #1;
        chk("fetch req grant", 64'(grant), 64'(2'b00));
        @(negedge clk);
        #1;
        chk("fetch grant", 64'(grant), 64'(2'b01));
        chk("fetch mem_addr", 64'(mem_addr), 64'(32'h100));
        chk("fetch mem_r_enable", 64'(mem_r_enable), 64'(1'b1));
        @(negedge clk);
        #1;
        chk("fetch wait ready", 64'(imem_rd_ready), 64'(1'b0));
        @(negedge clk);
        mem_ready  = 1'b1;
        mem_r_data = 32'h0000_0013;
        #1;
        chk("fetch imem_rd_ready", 64'(imem_rd_ready), 64'(1'b1));
        chk("fetch imem_rd_data", 64'(imem_rd_data), 64'(32'h13));
        chk("fetch dmem_ready", 64'(dmem_ready), 64'(1'b0));
        @(negedge clk);
        imem_rd_enable = 1'b0;
        mem_ready      = 1'b0;
        #1;
        chk("fetch after grant", 64'(grant), 64'(2'b00));

        // ---- store mirrors only while dmem owns the port ----
        do_reset();
        @(negedge clk);
        dmem_w_enable = 1'b1;
        dmem_w_size   = 2'd2;
        dmem_w_data   = 32'hDEAD_BEEF;
        dmem_addr     = 32'h2000;
        #1;
        chk("store idle w_enable", 64'(mem_w_enable), 64'(1'b0));
        chk("store idle w_data", 64'(mem_w_data), 64'(32'h0));
        @(negedge clk);
        #1;
        chk("store grant", 64'(grant), 64'(2'b10));
        chk("store w_enable", 64'(mem_w_enable), 64'(1'b1));
        chk("store w_size", 64'(mem_w_size), 64'(2'd2));
        chk("store w_data", 64'(mem_w_data), 64'(32'hDEAD_BEEF));
        chk("store addr", 64'(mem_addr), 64'(32'h2000));
        chk("store r_enable", 64'(mem_r_enable), 64'(1'b0));
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("store dmem_ready", 64'(dmem_ready), 64'(1'b1));
        chk("store imem_rd_ready", 64'(imem_rd_ready), 64'(1'b0));
        @(negedge clk);
        dmem_w_enable = 1'b0;
        mem_ready     = 1'b0;
        #1;
        chk("store after grant", 64'(grant), 64'(2'b00));
        chk("store after w_enable", 64'(mem_w_enable), 64'(1'b0));
        chk("store after w_data", 64'(mem_w_data), 64'(32'h0));
        chk("store after w_size", 64'(mem_w_size), 64'(2'd0));

        // ---- both requesting continuously, memory always ready ----
        do_reset();
        @(negedge clk);
        imem_rd_enable = 1'b1;
        dmem_r_enable  = 1'b1;
        mem_ready      = 1'b1;
        k = 0;
        for (int c = 0; c < 9; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (c % 2 == 0) begin
                exp_g = 2'b00;
            end else begin
                exp_g = (RR && (k % 2 == 0)) ? 2'b01 : 2'b10;
                k++;
            end
            chk($sformatf("b2b grant c%0d", c), 64'(grant), 64'(exp_g));
        end

        // ---- async reset in the middle of a dmem access ----
        do_reset();
        @(negedge clk);
        dmem_r_enable = 1'b1;
        dmem_addr     = 32'h44;
        @(negedge clk);
        #1;
        chk("mid grant before rst", 64'(grant), 64'(2'b10));
        chk("mid r_enable before rst", 64'(mem_r_enable), 64'(1'b1));
        #2;
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("mid rst grant", 64'(grant), 64'(2'b00));
        chk("mid rst r_enable", 64'(mem_r_enable), 64'(1'b0));
        chk("mid rst mem_addr", 64'(mem_addr), 64'(32'h0));
        chk("mid rst dmem_ready", 64'(dmem_ready), 64'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("post rst edge1 grant", 64'(grant), 64'(2'b00));
        chk("post rst edge1 dmem_ready", 64'(dmem_ready), 64'(1'b0));
        @(negedge clk);
        #1;
        chk("post rst edge2 grant", 64'(grant), 64'(2'b10));
        @(negedge clk);
        dmem_r_enable = 1'b0;
        mem_ready     = 1'b0;

        // ---- randomized traffic against the transaction model ----
        do_reset();
        owner = 0; waited = 0; completions = 0; err_pend = 1'b0;
        i_act = 1'b0; d_act = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_size = 2'd0; d_data = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            // requesters: start new requests or occasionally abandon one
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act  = 1'b1;
                i_addr = $urandom;
            end else if (i_act && $urandom_range(0, 19) == 0) begin
                i_act = 1'b0;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act  = 1'b1;
                k      = $urandom_range(0, 9);
                d_rd   = (k < 5);
                d_wr   = (k >= 5) || (k == 0);
                d_addr = $urandom;
                d_size = 2'($urandom_range(0, 2));
                d_data = $urandom;
            end else if (d_act && $urandom_range(0, 19) == 0) begin
                d_act = 1'b0;
            end
            imem_rd_enable = i_act;
            imem_rd_addr   = i_addr;
            dmem_r_enable  = d_act && d_rd;
            dmem_w_enable  = d_act && d_wr;
            dmem_addr      = d_addr;
            dmem_w_size    = d_size;
            dmem_w_data    = d_data;
            mem_ready      = ($urandom_range(0, 2) == 0);
            mem_r_data     = $urandom;
            #1;

            // expected outputs from the current owner
            exp_g    = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
            exp_ir   = (owner == 1) && mem_ready;
            exp_dr   = (owner == 2) && mem_ready;
            exp_addr = (owner == 1) ? i_addr : (owner == 2) ? d_addr : '0;
            exp_re   = (owner == 1) ? i_act : (owner == 2) ? (d_act && d_rd) : 1'b0;
            exp_we   = (owner == 2) ? (d_act && d_wr) : 1'b0;
            exp_sz   = (owner == 2) ? d_size : 2'd0;
            exp_wd   = (owner == 2) ? d_data : '0;
            if (exp_ir || exp_dr) exp_q.push_back(mem_r_data);

            chk("rnd grant", 64'(grant), 64'(exp_g));
            chk("rnd timeout_err", 64'(timeout_err), 64'(err_pend));
            chk("rnd imem_rd_ready", 64'(imem_rd_ready), 64'(exp_ir));
            chk("rnd dmem_ready", 64'(dmem_ready), 64'(exp_dr));
            chk("rnd mem_addr", 64'(mem_addr), 64'(exp_addr));
            chk("rnd mem_r_enable", 64'(mem_r_enable), 64'(exp_re));
            chk("rnd mem_w_enable", 64'(mem_w_enable), 64'(exp_we));
            chk("rnd mem_w_size", 64'(mem_w_size), 64'(exp_sz));
            chk("rnd mem_w_data", 64'(mem_w_data), 64'(exp_wd));
            if (imem_rd_ready || dmem_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd unexpected ready", 64'(1), 64'(0));
                end else begin
                    popped = exp_q.pop_front();
                    chk("rnd read data", 64'(imem_rd_ready ? imem_rd_data : dmem_r_data), 64'(popped));
                end
            end

            // advance the model by one clock
            err_pend = 1'b0;
            if (owner != 0) begin
                req = (owner == 1) ? i_act : (d_act && (d_rd || d_wr));
                if (mem_ready) begin
                    completions++;
                    if (owner == 1) i_act = 1'b0;
                    else            d_act = 1'b0;
                    owner = 0;
                end else if (!req) begin
                    owner = 0;
                end else begin
                    waited++;
                    if (waited == TO) begin
                        owner    = 0;
                        err_pend = 1'b1;
                    end
                end
            end else begin
                waited = 0;
                if (d_act && i_act) owner = (RR && (completions % 2 == 0)) ? 1 : 2;
                else if (d_act)     owner = 2;
                else if (i_act)     owner = 1;
            end
        end
        chk("scoreboard drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter TIMEOUT, default 255: max wait cycles for mem_ready, range 1..255.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port imem_rd_addr  in  ADDR_W  fetch address.
REQ-007 SHALL have port imem_rd_enable  in  1  fetch request, held until imem_rd_ready.
REQ-008 SHALL have port imem_rd_data  out  DATA_W  fetch data, valid with imem_rd_ready.
REQ-009 SHALL have port imem_rd_ready  out  1  fetch completion pulse.
REQ-010 SHALL have port dmem_addr  in  ADDR_W  load/store address.
REQ-011 SHALL have port dmem_r_enable  in  1  load request, held until dmem_ready.
REQ-012 SHALL have port dmem_w_enable  in  1  store request, held until dmem_ready.
REQ-013 SHALL have port dmem_w_size  in  2  store size: 0 byte, 1 half, 2 word.
REQ-014 SHALL have port dmem_w_data  in  DATA_W  store data.
REQ-015 SHALL have port dmem_r_data  out  DATA_W  load data, valid with dmem_ready.
REQ-016 SHALL have port dmem_ready  out  1  load/store completion pulse.
REQ-017 SHALL have ports mem_addr/mem_r_enable/mem_w_enable/mem_w_size/mem_w_data  out  ADDR_W/1/1/2/DATA_W  shared memory port.
REQ-018 SHALL have ports mem_r_data  in  DATA_W  and mem_ready  in  1  shared memory response.
REQ-019 SHALL have port grant  out  2  one-hot owner: bit0 imem, bit1 dmem, 00 idle.
REQ-020 SHALL have port timeout_err  out  1  one-cycle pulse on access timeout.

Function
REQ-021 SHALL implement FSM states IDLE, GNT_I, GNT_D.
REQ-022 IDLE: dmem request (r or w enable) -> GNT_D; else imem_rd_enable -> GNT_I; else stay; arbitration latency exactly one cycle.
REQ-023 In GNT_x, mem_* outputs SHALL combinationally mirror owner's addr/enables/size/data; in IDLE all mem enables 0, mem_addr/mem_w_data 0.
REQ-024 Owner ready = mem_ready in owner state; non-owner ready SHALL be 0 always.
REQ-025 imem_rd_data and dmem_r_data SHALL both pass mem_r_data unregistered.
REQ-026 mem_ready in GNT_x SHALL return FSM to IDLE next cycle; one idle cycle between consecutive grants (back-to-back throughput 1 access per 2+ cycles).
REQ-027 mem_ready in IDLE SHALL be ignored.
REQ-028 Owner dropping all its enables before mem_ready SHALL abort: IDLE next cycle, no ready, no error.
REQ-029 Wait counter (8 bits) SHALL clear on grant entry, increment each GNT_x cycle without mem_ready; on reaching TIMEOUT, pulse timeout_err, go IDLE, no ready.
REQ-030 dmem_r_enable and dmem_w_enable both high SHALL forward both unchanged; conflict resolution belongs to memory.

Reset
REQ-031 On reset assertion, immediately and independent of clk: state IDLE, counter 0, RR pointer to imem, grant 00, timeout_err 0, mem enables 0, both readies 0.
REQ-032 Reset mid-access SHALL drop the access with no ready; first grant possible on second rising edge after deassertion.

Configuration
REQ-033 Macro MEM_ARB_RR_EN defined: when both request in IDLE, grant alternates via a pointer toggled on every completed grant; single requester granted regardless of pointer.
REQ-034 Macro MEM_ARB_RR_EN undefined: fixed dmem priority per REQ-022; no pointer state.

Verification
REQ-035 imem_rd_enable=1, addr 0x100, mem_ready 2 cycles after grant, mem_r_data 0x00000013 -> grant=01 cycle 1, imem_rd_ready pulse with data 0x13, dmem_ready 0.
REQ-036 Both requests held continuously, mem_ready immediate, without MEM_ARB_RR_EN -> grant sequence 10,00,10,00...; with it -> 01/10 alternating.
REQ-037 dmem store 0xDEADBEEF size 2 addr 0x2000 -> mem_w_enable=1, mem_w_size=2, mem_w_data 0xDEADBEEF only while grant=10.
REQ-038 TIMEOUT=4, mem_ready never -> timeout_err pulse 4 cycles after grant, FSM IDLE, no ready.
REQ-039 reset asserted mid-GNT_D between clock edges -> mem enables and grant 0 before next edge; no dmem_ready.
